combo_prog_ctrl: RTL and testbench
==================================

# combo_prog_ctrl

Combination store and programming sequencer for the safe. Holds the three-number combination that feeds the dial comparator, indexed by the master FSM's digit select. Lets the user re-program the combination while the safe is unlocked, and commits the new values atomically. Optionally enforces a timed lockout after repeated failed opening attempts.

## Interface
Parameters:
- DIAL_W, 6: width of dial position and stored digits.
- DIAL_MAX, 59: highest legal dial position.
- DEF0, 10: reset value of digit 0.
- DEF1, 20: reset value of digit 1.
- DEF2, 30: reset value of digit 2.
- MAX_FAIL, 3: number of failed attempts that triggers lockout.
- LOCKOUT_CYC, 1000: lockout duration in clk cycles (≥2).

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- safeOpen  in  1  master reports the unlocked state.
- sel  in  2  master's digit select (0..2; 3 treated as 0).
- dial  in  DIAL_W  current dial count.
- prog  in  1  single-cycle debounced "program" button pulse.
- enter  in  1  single-cycle debounced "enter" button pulse.
- failPulse  in  1  single-cycle pulse, one per bad combination attempt.
- code  out  DIAL_W  committed digit selected by sel; feeds the comparator.
- progActive  out  1  programming in progress.
- progDigit  out  2  digit being entered (0..2); 3 = awaiting confirm.
- commitDone  out  1  one-cycle pulse when the new combination is committed.
- entryErr  out  1  one-cycle pulse when an enter is rejected (dial > DIAL_MAX).
- lockout  out  1  attempt lockout active; the top level blocks open while high.

## Operation
- Committed registers C0..C2 and shadow registers S0..S2 each hold DIAL_W bits.
- code = C[sel], combinational, with zero latency to the comparator.
- Only the commit event writes C0..C2; partial programming never changes code.
- FSM states: IDLE, P0, P1, P2, CONF.
  - IDLE → P0 on prog & safeOpen. prog without safeOpen is ignored.
  - Pn → Pn+1 (P2 → CONF) on enter with dial ≤ DIAL_MAX. The same edge captures Sn ← dial.
  - Pn with enter and dial > DIAL_MAX: stay in Pn, pulse entryErr, leave Sn unchanged.
  - CONF → IDLE on enter. C0..C2 ← S0..S2 and commitDone pulses. dial is don't-care in CONF.
  - Any non-IDLE state → IDLE on prog (cancel) or on safeOpen low (abort). Neither commits.
  - Priority: abort > cancel > enter.
- Lockout (COMBO_LOCKOUT_EN):
  - failCnt counts 0..MAX_FAIL and increments on failPulse. failPulse is ignored while lockout is high.
  - When the increment reaches MAX_FAIL: lockout ← 1 and the timer ← LOCKOUT_CYC-1.
  - The timer decrements once per cycle while lockout is high. On the cycle the timer is 0, lockout ← 0 and failCnt ← 0.
  - safeOpen high clears failCnt. If safeOpen and failPulse occur in the same cycle, the clear wins.
  - The timer width is $clog2(LOCKOUT_CYC).

## Timing
- Reset values:
  - C0/C1/C2 = DEF0/DEF1/DEF2; S0..S2 = 0.
  - State IDLE; progActive, progDigit, commitDone, entryErr, lockout all 0.
  - failCnt and timer 0.
- All outputs except code are registered.
- progActive and progDigit update on the clk edge that takes the transition.
- commitDone and entryErr are high for exactly the one cycle after the triggering enter edge.
- C registers take new values on the same edge that raises commitDone. code reflects them in that cycle.
- lockout rises the cycle after the MAX_FAIL-th failPulse. It stays high for exactly LOCKOUT_CYC cycles.
- rst mid-programming returns to IDLE and restores DEF0..DEF2. Any previously committed combination is lost.

## Configuration
- COMBO_LOCKOUT_EN defined: failCnt, the timer and the lockout logic are compiled in, as described above.
- COMBO_LOCKOUT_EN undefined:
  - lockout is tied to 0 and failPulse is ignored.
  - No failCnt or timer flops exist.
  - All other behaviour is identical.

## Test plan
- Reset, then sel = 0/1/2 → code = 10/20/30; every registered output is 0.
- safeOpen = 1; prog; dial = 5, enter; dial = 42, enter; dial = 17, enter; enter → commitDone pulses once; sel 0/1/2 → code 5/42/17.
- Program with digits 1 and 2 entered, then prog → IDLE, no commitDone, code still 10/20/30. Repeat, dropping safeOpen in CONF → same result.
- In P1 with dial = 63, enter → entryErr for 1 cycle, progDigit stays 1. Then dial = 59, enter → progDigit = 2.
- Lockout with LOCKOUT_CYC = 8:
  - Three failPulses → lockout high for 8 cycles starting the cycle after the third pulse.
  - A failPulse during lockout is ignored.
  - After lockout ends, one failPulse does not re-trigger it.
- Two failPulses, then safeOpen with a simultaneous failPulse → failCnt = 0. A further two failPulses do not trigger lockout. Macro undefined: lockout never rises.

Source files
------------

// File: rtl/combo_prog_ctrl.sv
// combo_prog_ctrl: stores the safe's three-number combination and sequences its
// re-programming while the safe is unlocked; new values are committed atomically.
// Optional feature macro: COMBO_LOCKOUT_EN adds a timed lockout after MAX_FAIL
// failed opening attempts (when undefined, lockout is tied low).
module combo_prog_ctrl #(
    parameter int DIAL_W      = 6,
    parameter int DIAL_MAX    = 59,
    parameter int DEF0        = 10,
    parameter int DEF1        = 20,
    parameter int DEF2        = 30,
    parameter int MAX_FAIL    = 3,
    parameter int LOCKOUT_CYC = 1000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              safeOpen,
    input  logic [1:0]        sel,
    input  logic [DIAL_W-1:0] dial,
    input  logic              prog,
    input  logic              enter,
    input  logic              failPulse,
    output logic [DIAL_W-1:0] code,
    output logic              progActive,
    output logic [1:0]        progDigit,
    output logic              commitDone,
    output logic              entryErr,
    output logic              lockout
);

    typedef enum logic [2:0] {IDLE, P0, P1, P2, CONF} stateT;

    stateT             state;
    stateT             stateNext;
    logic [DIAL_W-1:0] c0, c1, c2;
    logic [DIAL_W-1:0] s0, s1, s2;
    logic              cap0, cap1, cap2;
    logic              doCommit;
    logic              errNow;
    logic              dialOk;
    logic [1:0]        progDigitNext;

    assign dialOk = (dial <= DIAL_W'(DIAL_MAX));

    // Committed digit for the comparator, sel==3 aliases digit 0
    always_comb begin
        code = c0;
        case (sel)
            2'd1:    code = c1;
            2'd2:    code = c2;
            default: code = c0;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= stateNext;
    end

    // Next state and capture/commit strobes; abort beats cancel beats enter
    always_comb begin
        stateNext     = state;
        cap0          = 1'b0;
        cap1          = 1'b0;
        cap2          = 1'b0;
        doCommit      = 1'b0;
        errNow        = 1'b0;
        progDigitNext = 2'd0;
        if (state == IDLE) begin
            if (prog && safeOpen) stateNext = P0;
        end else if (!safeOpen || prog) begin
            stateNext = IDLE;
        end else if (enter) begin
            case (state)
                P0: begin
                    if (dialOk) begin stateNext = P1; cap0 = 1'b1; end
                    else errNow = 1'b1;
                end
                P1: begin
                    if (dialOk) begin stateNext = P2; cap1 = 1'b1; end
                    else errNow = 1'b1;
                end
                P2: begin
                    if (dialOk) begin stateNext = CONF; cap2 = 1'b1; end
                    else errNow = 1'b1;
                end
                CONF: begin
                    stateNext = IDLE;
                    doCommit  = 1'b1;
                end
                default: stateNext = IDLE;
            endcase
        end
        case (stateNext)
            P1:      progDigitNext = 2'd1;
            P2:      progDigitNext = 2'd2;
            CONF:    progDigitNext = 2'd3;
            default: progDigitNext = 2'd0;
        endcase
    end

    // Registered status outputs follow the transition being taken
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            progActive <= 1'b0;
            progDigit  <= 2'd0;
            commitDone <= 1'b0;
            entryErr   <= 1'b0;
        end else begin
            progActive <= (stateNext != IDLE);
            progDigit  <= progDigitNext;
            commitDone <= doCommit;
            entryErr   <= errNow;
        end
    end

    // Shadow digits captured on accepted enters; committed set copied only on confirm
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s0 <= '0;
            s1 <= '0;
            s2 <= '0;
            c0 <= DIAL_W'(DEF0);
            c1 <= DIAL_W'(DEF1);
            c2 <= DIAL_W'(DEF2);
        end else begin
            if (cap0) s0 <= dial;
            if (cap1) s1 <= dial;
            if (cap2) s2 <= dial;
            if (doCommit) begin
                c0 <= s0;
                c1 <= s1;
                c2 <= s2;
            end
        end
    end

`ifdef COMBO_LOCKOUT_EN
    localparam int TW  = $clog2(LOCKOUT_CYC);
    localparam int FCW = $clog2(MAX_FAIL + 1);

    logic [FCW-1:0] failCnt;
    logic [TW-1:0]  timer;

    // Failed-attempt counter and lockout timer; an open safe forgives past failures
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            failCnt <= '0;
            timer   <= '0;
            lockout <= 1'b0;
        end else if (lockout) begin
            if (timer == '0) begin
                lockout <= 1'b0;
                failCnt <= '0;
            end else begin
                timer <= timer - 1'b1;
                if (safeOpen) failCnt <= '0;
            end
        end else if (safeOpen) begin
            failCnt <= '0;
        end else if (failPulse) begin
            if (failCnt == FCW'(MAX_FAIL - 1)) begin
                failCnt <= FCW'(MAX_FAIL);
                lockout <= 1'b1;
                timer   <= TW'(LOCKOUT_CYC - 1);
            end else begin
                failCnt <= failCnt + 1'b1;
            end
        end
    end
`else
    localparam int unusedLockCfg = MAX_FAIL + LOCKOUT_CYC;
    logic unusedFailPulse;
    assign unusedFailPulse = failPulse;
    assign lockout         = 1'b0;
`endif

endmodule

// File: tb/tb_combo_prog_ctrl.sv
// tb_combo_prog_ctrl: directed bench for combo_prog_ctrl with a scoreboard that
// matches commitDone/entryErr pulses against expected events.
module tb_combo_prog_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       safeOpen;
    logic [1:0] sel;
    logic [5:0] dial;
    logic       prog;
    logic       enter;
    logic       failPulse;
    logic [5:0] code;
    logic       progActive;
    logic [1:0] progDigit;
    logic       commitDone;
    logic       entryErr;
    logic       lockout;

    typedef struct {
        int kind;
        int digit;
    } expT;

    expT sbQ[$];
    int  total = 0;
    int  bad   = 0;
    int  hiCnt;

    localparam int K_COMMIT = 0;
    localparam int K_ERR    = 1;

    combo_prog_ctrl #(
        .DIAL_W(6), .DIAL_MAX(59), .DEF0(10), .DEF1(20), .DEF2(30),
        .MAX_FAIL(3), .LOCKOUT_CYC(8)
    ) dut (
        .clk(clk), .rst(rst), .safeOpen(safeOpen), .sel(sel), .dial(dial),
        .prog(prog), .enter(enter), .failPulse(failPulse), .code(code),
        .progActive(progActive), .progDigit(progDigit), .commitDone(commitDone),
        .entryErr(entryErr), .lockout(lockout)
    );

    always #5 clk = ~clk;

    // Compare one observed value against its required value
    task automatic checkOutput(input string name, input int actual, input int expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Drive one cycle of button/fail pulses with a dial value, then release the pulses
    task automatic applyStimulus(input logic p, input logic e, input logic f, input logic [5:0] d);
        prog      = p;
        enter     = e;
        failPulse = f;
        dial      = d;
        @(posedge clk);
        #1;
        prog      = 1'b0;
        enter     = 1'b0;
        failPulse = 1'b0;
    endtask

    task automatic checkCodes(input string tag, input int e0, input int e1, input int e2);
        sel = 2'd0; #1; checkOutput({tag, "_code0"}, int'(code), e0);
        sel = 2'd1; #1; checkOutput({tag, "_code1"}, int'(code), e1);
        sel = 2'd2; #1; checkOutput({tag, "_code2"}, int'(code), e2);
        sel = 2'd0;
    endtask

    // Monitor: every commitDone/entryErr cycle must match the next expected event
    always @(negedge clk) begin
        if (!rst && (commitDone || entryErr)) begin
            total++;
            if (sbQ.size() == 0) begin
                bad++;
                $display("[TB] FAIL sbUnexpected: got commitDone=%0b entryErr=%0b, expected no pulse",
                         commitDone, entryErr);
            end else begin
                expT e;
                e = sbQ.pop_front();
                if ((entryErr ? K_ERR : K_COMMIT) != e.kind || int'(progDigit) != e.digit
                    || (commitDone && entryErr)) begin
                    bad++;
                    $display("[TB] FAIL sbEvent: got kind=%0d digit=%0d, expected kind=%0d digit=%0d",
                             entryErr ? K_ERR : K_COMMIT, progDigit, e.kind, e.digit);
                end
            end
        end
    end

    initial begin
        rst = 1'b1; safeOpen = 1'b0; sel = 2'd0; dial = '0;
        prog = 1'b0; enter = 1'b0; failPulse = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        checkOutput("rstProgActive", progActive, 0);
        checkOutput("rstProgDigit", progDigit, 0);
        checkOutput("rstCommitDone", commitDone, 0);
        checkOutput("rstEntryErr", entryErr, 0);
        checkOutput("rstLockout", lockout, 0);
        checkCodes("rst", 10, 20, 30);
        sel = 2'd3; #1; checkOutput("sel3Alias", code, 10); sel = 2'd0;

        // prog without safeOpen is ignored
        applyStimulus(1, 0, 0, 0);
        checkOutput("progClosed", progActive, 0);

        // Full programming and commit
        safeOpen = 1'b1;
        applyStimulus(1, 0, 0, 0);
        checkOutput("p0Active", progActive, 1);
        checkOutput("p0Digit", progDigit, 0);
        applyStimulus(0, 1, 0, 6'd5);
        checkOutput("p1Digit", progDigit, 1);
        applyStimulus(0, 1, 0, 6'd42);
        checkOutput("p2Digit", progDigit, 2);
        applyStimulus(0, 1, 0, 6'd17);
        checkOutput("confDigit", progDigit, 3);
        checkCodes("preCommit", 10, 20, 30);
        sbQ.push_back('{K_COMMIT, 0});
        applyStimulus(0, 1, 0, 6'd63);
        checkOutput("commitActive", progActive, 0);
        checkCodes("commit", 5, 42, 17);
        applyStimulus(0, 0, 0, 0);
        checkOutput("commitOneCycle", commitDone, 0);

        // Reset mid-programming restores defaults
        applyStimulus(1, 0, 0, 0);
        applyStimulus(0, 1, 0, 6'd7);
        rst = 1'b1; #2; rst = 1'b0;
        checkOutput("midRstActive", progActive, 0);
        checkCodes("midRst", 10, 20, 30);

        // Cancel after two digits
        applyStimulus(1, 0, 0, 0);
        applyStimulus(0, 1, 0, 6'd1);
        applyStimulus(0, 1, 0, 6'd2);
        checkOutput("cancelDigit", progDigit, 2);
        applyStimulus(1, 0, 0, 0);
        checkOutput("cancelActive", progActive, 0);
        checkCodes("cancel", 10, 20, 30);

        // Abort from CONF by dropping safeOpen
        applyStimulus(1, 0, 0, 0);
        applyStimulus(0, 1, 0, 6'd1);
        applyStimulus(0, 1, 0, 6'd2);
        applyStimulus(0, 1, 0, 6'd3);
        checkOutput("abortConf", progDigit, 3);
        safeOpen = 1'b0;
        applyStimulus(0, 1, 0, 0);
        checkOutput("abortActive", progActive, 0);
        checkCodes("abort", 10, 20, 30);

        // Out-of-range entry rejected, boundary value accepted
        safeOpen = 1'b1;
        applyStimulus(1, 0, 0, 0);
        applyStimulus(0, 1, 0, 6'd3);
        sbQ.push_back('{K_ERR, 1});
        applyStimulus(0, 1, 0, 6'd63);
        checkOutput("errDigit", progDigit, 1);
        checkOutput("errPulse", entryErr, 1);
        applyStimulus(0, 0, 0, 0);
        checkOutput("errOneCycle", entryErr, 0);
        applyStimulus(0, 1, 0, 6'd59);
        checkOutput("maxDigit", progDigit, 2);
        // cancel outranks a simultaneous enter
        applyStimulus(1, 1, 0, 6'd4);
        checkOutput("cancelOverEnter", progActive, 0);
        checkCodes("afterErr", 10, 20, 30);

        // Lockout behaviour
        safeOpen = 1'b0;
`ifdef COMBO_LOCKOUT_EN
        applyStimulus(0, 0, 1, 0);
        applyStimulus(0, 0, 1, 0);
        checkOutput("lockEarly", lockout, 0);
        applyStimulus(0, 0, 1, 0);
        checkOutput("lockRise", lockout, 1);
        hiCnt = 1;
        for (int i = 0; i < 40 && lockout; i++) begin
            applyStimulus(0, 0, (i == 2), 0);
            if (lockout) hiCnt++;
        end
        checkOutput("lockLen", hiCnt, 8);
        applyStimulus(0, 0, 1, 0);
        applyStimulus(0, 0, 0, 0);
        checkOutput("noRetrigger", lockout, 0);
        applyStimulus(0, 0, 1, 0);
        safeOpen = 1'b1;
        applyStimulus(0, 0, 1, 0);
        safeOpen = 1'b0;
        applyStimulus(0, 0, 1, 0);
        applyStimulus(0, 0, 1, 0);
        applyStimulus(0, 0, 0, 0);
        checkOutput("clearWins", lockout, 0);
`else
        hiCnt = 0;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(0, 0, 1, 0);
            if (lockout) hiCnt++;
        end
        checkOutput("noLockout", hiCnt, 0);
`endif

        repeat (2) @(posedge clk);
        #1;
        checkOutput("sbDrain", sbQ.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
